dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl_pkg.sv | 26 ++
 rtl/dcache_sram.sv | 49 ++++
 rtl/dcache_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared types and geometry for the data cache controller
// Contents: FSM state enum, cache geometry constants, line address helper.
package dcache_ctrl_pkg;

  localparam int LINE_W = 256;
  localparam int SETS   = 16;
  localparam int TAG_W  = 23;
  localparam int IDX_W  = 4;
  localparam int WORD_W = 32;
  localparam int OFF_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_READMISS,
    S_READMISSOK
  } state_t;

  // Memory-side line address: byte offset bits forced to zero.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - direct-mapped line storage with one write port and async read
// Ports: clk, rst (async, active-high, clears valid/dirty only); we, idx, wr_tag,
//        wr_dirty, wr_line (write port, every write marks the set valid);
//        rd_valid, rd_dirty, rd_tag, rd_line (combinational read of set idx).
module dcache_sram
  import dcache_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_dirty,
  input  logic [LINE_W-1:0] wr_line,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= wr_dirty;
    end
  end

  // Tags and data are meaningless while valid is low, so they carry no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[idx]  <= wr_tag;
      data_q[idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - write-back, write-allocate direct-mapped data cache controller
// Ports: clk_i, rst_i (async, active-high); cpu_req_i, cpu_write_i, cpu_addr_i,
//        cpu_data_i, cpu_data_o, cpu_stall_o (MEM-stage side); mem_enable_o,
//        mem_write_o, mem_addr_o, mem_data_o, mem_data_i, mem_ack_i (line memory side).
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  state_t state;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        wsel;
  logic              rd_valid;
  logic              rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [LINE_W-1:0] wr_line;
  logic              hit;
  logic              store_hit;
  logic              fill;
  logic              we;
  logic              unused_byte_sel;

  assign tag  = cpu_addr_i[31:9];
  assign idx  = cpu_addr_i[8:5];
  assign wsel = cpu_addr_i[4:2];
  assign unused_byte_sel = ^cpu_addr_i[1:0];

  assign hit       = cpu_req_i & rd_valid & (rd_tag == tag);
  assign store_hit = (state == S_IDLE) & hit & cpu_write_i;
  assign fill      = (state == S_READMISS) & mem_ack_i;
  assign we        = store_hit | fill;

  // Fill and store-hit live in different states, so one write port suffices.
  always_comb begin
    wr_line = rd_line;
    if (fill) begin
      wr_line = mem_data_i;
    end else begin
      wr_line[wsel*WORD_W +: WORD_W] = cpu_data_i;
    end
  end

  dcache_sram u_sram (
    .clk      (clk_i),
    .rst      (rst_i),
    .we       (we),
    .idx      (idx),
    .wr_tag   (tag),
    .wr_dirty (~fill),
    .wr_line  (wr_line),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line)
  );

  assign cpu_data_o  = rd_line[wsel*WORD_W +: WORD_W];
  assign cpu_stall_o = (state == S_IDLE) ? (cpu_req_i & ~hit) : 1'b1;

  // The set is untouched until the fill, so the read port still shows the victim.
  assign mem_addr_o = (state == S_WRITEBACK) ? line_addr(rd_tag, idx)
                                             : line_addr(tag, idx);
  assign mem_data_o = rd_line;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req_i && !hit) state <= S_MISS;
        end
        S_MISS: begin
          mem_enable_o <= 1'b1;
          if (rd_valid && rd_dirty) begin
            state       <= S_WRITEBACK;
            mem_write_o <= 1'b1;
          end else begin
            state       <= S_READMISS;
            mem_write_o <= 1'b0;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            state       <= S_READMISS;
            mem_write_o <= 1'b0;
          end
        end
        S_READMISS: begin
          if (mem_ack_i) begin
            state        <= S_READMISSOK;
            mem_enable_o <= 1'b0;
          end
        end
        S_READMISSOK: begin
          state <= S_IDLE;
        end
        default: begin
          state        <= S_IDLE;
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
